// File: rtl/seq_detector_param_if.sv
// Bundles the configuration, serial-input and detection-result signals of
// seq_detector_param. The master drives the inputs and the slave is the detector.
interface seq_detector_param_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               in_valid;
  logic               seq_in;
  logic               det_out;
  logic [CNT_W-1:0]   det_count;
  logic               count_sat;
  logic               cfg_err;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr, in_valid, seq_in,
    input  det_out, det_count, count_sat, cfg_err
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr, in_valid, seq_in,
    output det_out, det_count, count_sat, cfg_err
  );
endinterface

// File: rtl/seq_detector_param.sv
// Run-time programmable serial pattern detector with overlapping or restart-after-match
// behaviour, a registered detect pulse and a saturating match counter.
module seq_detector_param #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0001_0110),
  parameter logic [LEN_W-1:0]   DEF_LEN     = LEN_W'(5),
  parameter logic               DEF_OVERLAP = 1'b1
) (
  input logic               clk,
  input logic               rst,
  seq_detector_param_if.slave bus
);

  localparam logic [LEN_W:0] MAX_LEN_X = (LEN_W + 1)'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   det_count_q, det_count_d;
  logic               det_out_q, det_out_d;
  logic               cfg_err_q, cfg_err_d;

  logic               cfg_ok;
  logic               accept;
  logic               match;
  logic               count_full;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_plus;

  // Only the low len bits of history take part in the comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  always_comb begin
    cfg_ok     = (bus.cfg_len != '0) && ({1'b0, bus.cfg_len} <= MAX_LEN_X);
    accept     = bus.in_valid && !bus.cfg_load;
    hist_next  = {hist_q[MAX_LEN-2:0], bus.seq_in};
    fill_plus  = {1'b0, fill_q} + (LEN_W + 1)'(1);
    count_full = &det_count_q;
    match      = accept
                 && (fill_plus >= {1'b0, len_q})
                 && (((hist_next ^ pattern_q) & len_mask) == '0);
  end

  always_comb begin
    pattern_d   = pattern_q;
    len_d       = len_q;
    overlap_d   = overlap_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    det_count_d = det_count_q;
    det_out_d   = 1'b0;
    cfg_err_d   = 1'b0;

    if (bus.cfg_load) begin
      // A rejected load leaves everything alone; the input bit is dropped either way.
      if (cfg_ok) begin
        pattern_d   = bus.cfg_pattern;
        len_d       = bus.cfg_len;
        overlap_d   = bus.cfg_overlap;
        hist_d      = '0;
        fill_d      = '0;
        det_count_d = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      if (accept) begin
        hist_d = hist_next;
        if (match) begin
          fill_d = overlap_q ? len_q : '0;
        end else if (fill_q < len_q) begin
          fill_d = fill_plus[LEN_W-1:0];
        end
      end

      if (bus.cnt_clr) begin
        det_count_d = match ? CNT_W'(1) : '0;
      end else if (match && !count_full) begin
        det_count_d = det_count_q + CNT_W'(1);
      end

      det_out_d = match;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q   <= DEF_PATTERN;
      len_q       <= DEF_LEN;
      overlap_q   <= DEF_OVERLAP;
      hist_q      <= '0;
      fill_q      <= '0;
      det_count_q <= '0;
      det_out_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      overlap_q   <= overlap_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      det_count_q <= det_count_d;
      det_out_q   <= det_out_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.det_out   = det_out_q;
  assign bus.det_count = det_count_q;
  assign bus.count_sat = count_full;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a queue-based model.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [MAX_LEN-1:0] DEF_PAT = 8'b0001_0110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   check_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [MAX_LEN-1:0] m_pat = DEF_PAT;
  int   m_len = 5;
  bit   m_ovl = 1'b1;
  bit   m_hist[$];
  int   m_fresh = 0;
  int   m_count = 0;
  bit   exp_det = 1'b0;
  bit   exp_err = 1'b0;

  always #5 clk = ~clk;

  seq_detector_param_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_detector_param #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W),
    .DEF_PATTERN(DEF_PAT), .DEF_LEN(4'd5), .DEF_OVERLAP(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
    end
  endtask

  // Model: the last accepted bits as a queue plus a count of bits since the last restart.
  always @(posedge clk) begin
    if (rst) begin
      m_pat = DEF_PAT; m_len = 5; m_ovl = 1'b1;
      m_hist.delete(); m_fresh = 0; m_count = 0;
      exp_det = 1'b0; exp_err = 1'b0;
    end else begin : step
      bit hit;
      hit = 1'b0;
      exp_det = 1'b0;
      exp_err = 1'b0;
      if (bus.cfg_load) begin
        if (bus.cfg_len >= 1 && bus.cfg_len <= MAX_LEN) begin
          m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len); m_ovl = bus.cfg_overlap;
          m_hist.delete(); m_fresh = 0; m_count = 0;
        end else begin
          exp_err = 1'b1;
        end
      end else begin
        if (bus.in_valid) begin
          m_hist.push_back(bus.seq_in);
          if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
          m_fresh++;
          if (m_fresh >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++)
              if (m_hist[m_hist.size() - 1 - i] != m_pat[i]) hit = 1'b0;
          end
          if (hit && !m_ovl) m_fresh = 0;
        end
        if (bus.cnt_clr) m_count = hit ? 1 : 0;
        else if (hit && m_count < CNT_MAX) m_count++;
        exp_det = hit;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cyc_det_out", bus.det_out, exp_det);
      checkOutput("cyc_det_count", bus.det_count, m_count);
      checkOutput("cyc_count_sat", bus.count_sat, (m_count == CNT_MAX));
      checkOutput("cyc_cfg_err", bus.cfg_err, exp_err);
    end
  end

  task automatic applyStimulus(input logic ld, input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                               input logic ovl, input logic clr, input logic vld, input logic b);
    bus.cfg_load    = ld;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.cnt_clr     = clr;
    bus.in_valid    = vld;
    bus.seq_in      = b;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic loadCfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len, input logic ovl);
    applyStimulus(1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleCycle();
    rst = 1'b0;
  endtask

  // Bits are sent MSB first; expv holds the literal det_out expected after each bit.
  task automatic runStream(input logic [15:0] bits, input int n, input logic [15:0] expv, input string tag);
    for (int k = 0; k < n; k++) begin
      sendBit(bits[n-1-k]);
      checkOutput($sformatf("%s_det_b%0d", tag, k + 1), bus.det_out, expv[n-1-k]);
      checkOutput($sformatf("%s_model_b%0d", tag, k + 1), exp_det, expv[n-1-k]);
    end
  endtask

  initial begin
    rst = 1'b1;
    idleCycle();
    check_en = 1'b1;
    idleCycle();
    rst = 1'b0;
    checkOutput("rst_det_out", bus.det_out, 0);
    checkOutput("rst_det_count", bus.det_count, 0);
    checkOutput("rst_count_sat", bus.count_sat, 0);
    checkOutput("rst_cfg_err", bus.cfg_err, 0);

    runStream(16'b1011_0110, 8, 16'b0000_1001, "t1");
    checkOutput("t1_count", bus.det_count, 2);
    checkOutput("t1_model_count", m_count, 2);

    loadCfg(8'b0001_0110, 4'd5, 1'b0);
    runStream(16'b1011_0110, 8, 16'b0000_1000, "t2");
    checkOutput("t2_count", bus.det_count, 1);

    loadCfg(8'b0001_0110, 4'd5, 1'b1);
    sendBit(1'b1);
    sendBit(1'b0);
    for (int k = 0; k < 3; k++) begin
      idleCycle();
      checkOutput("t3_gap_det", bus.det_out, 0);
    end
    runStream(16'b110, 3, 16'b001, "t3");
    checkOutput("t3_count", bus.det_count, 1);

    loadCfg(8'b0000_0001, 4'd1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      sendBit(1'b1);
      checkOutput("t4_det", bus.det_out, 1);
      checkOutput("t4_count", bus.det_count, (k + 1 > 3) ? 3 : k + 1);
    end
    checkOutput("t4_sat", bus.count_sat, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("t4_clr_match_count", bus.det_count, 1);
    checkOutput("t4_clr_match_det", bus.det_out, 1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_clr_count", bus.det_count, 0);

    loadCfg(8'b0001_0110, 4'd5, 1'b1);
    loadCfg(8'hFF, 4'd0, 1'b0);
    checkOutput("t5_err_len0", bus.cfg_err, 1);
    runStream(16'b1_0110, 5, 16'b0_0001, "t5a");
    loadCfg(8'h00, 4'd9, 1'b0);
    checkOutput("t5_err_len9", bus.cfg_err, 1);
    idleCycle();
    checkOutput("t5_err_clear", bus.cfg_err, 0);
    loadCfg(8'hA5, 4'd8, 1'b1);
    checkOutput("t5_ok_len8", bus.cfg_err, 0);
    runStream(16'hA5, 8, 16'h01, "t5b");

    doReset();
    runStream(16'b1011, 4, 16'b0, "t6a");
    doReset();
    sendBit(1'b0);
    checkOutput("t6_rst_det", bus.det_out, 0);
    runStream(16'b1011, 4, 16'b0, "t6b");
    applyStimulus(1'b1, 8'b0001_0110, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t6_load_det", bus.det_out, 0);
    runStream(16'b0110, 4, 16'b0, "t6c");

    for (int c = 0; c < 3000; c++) begin
      int r;
      int rl;
      logic ld;
      logic [LEN_W-1:0] l;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        doReset();
      end else begin
        ld = ($urandom_range(0, 99) < 3);
        rl = $urandom_range(0, 99);
        if (rl < 5) l = '0;
        else if (rl < 15) l = LEN_W'($urandom_range(MAX_LEN + 1, (1 << LEN_W) - 1));
        else if (rl < 55) l = LEN_W'($urandom_range(1, 3));
        else l = LEN_W'($urandom_range(1, MAX_LEN));
        applyStimulus(ld, MAX_LEN'($urandom), l, 1'($urandom),
                      $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 75, 1'($urandom));
      end
    end

    idleCycle();
    idleCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
